// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter slice.
// Holds the framebuffer geometry (address/data widths, number of valid
// words), the read-owner tag carried into the return cycle, the layout of
// one buffered pixel write, and a helper that decides whether an address
// falls inside the 160x144 framebuffer.
package fb_pkg;

    localparam int FB_AW    = 15;
    localparam int FB_DW    = 2;
    localparam int FB_WORDS = 23040;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_AI   = 2'd2
    } owner_t;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [FB_DW-1:0] data;
    } fifo_entry_t;

    // Zero-extend so the compare is done at 32 bits against the word count.
    function automatic logic addr_in_range(input logic [FB_AW-1:0] addr,
                                           input int unsigned      words);
        return ({17'd0, addr} < words);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO for buffered capture pixels.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, din      : store one entry (caller guarantees ready is high)
//   pop, dout      : drop the head entry (caller guarantees level != 0);
//                    dout always shows the current head
//   level          : occupancy 0..DEPTH
//   ready          : registered "level < DEPTH", low while in reset
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  fifo_entry_t                din,
    input  logic                       pop,
    output fifo_entry_t                dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    fifo_entry_t   mem [DEPTH];

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        level_next = level;
        if (push && !pop)
            level_next = level + LW'(1);
        else if (pop && !push)
            level_next = level - LW'(1);
    end

    // Ready is derived from the next level so it is already correct in the
    // cycle the FIFO becomes full or regains space.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            ready <= (level_next < FULL);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter for the capture writer, the VGA
// debug reader and the AI board sampler (25 MHz VGA clock domain).
// Ports:
//   clock, reset_n                  : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data : capture pixel writes into the FIFO
//   vga_req/vga_addr                : per-cycle VGA read request
//   vga_valid/vga_q/vga_miss        : VGA read return and lost-arbitration pulse
//   ai_req/ai_addr/ai_gnt           : held AI read request and its grant
//   ai_valid/ai_q                   : AI read return
//   ram_addr/ram_we/ram_wdata/ram_q : framebuffer RAM (one-cycle read latency)
//   fifo_level                      : write FIFO occupancy
//   overflow/clr_overflow           : sticky dropped-write flag and its clear
module fb_arbiter #(
    parameter int FB_WORDS   = fb_pkg::FB_WORDS,
    parameter int FIFO_DEPTH = 32,
    parameter int HI_WM      = 24
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [14:0]                   wr_addr,
    input  logic [1:0]                    wr_data,
    input  logic                          vga_req,
    input  logic [14:0]                   vga_addr,
    output logic                          vga_valid,
    output logic [1:0]                    vga_q,
    output logic                          vga_miss,
    input  logic                          ai_req,
    input  logic [14:0]                   ai_addr,
    output logic                          ai_gnt,
    output logic                          ai_valid,
    output logic [1:0]                    ai_q,
    output logic [14:0]                   ram_addr,
    output logic                          ram_we,
    output logic [1:0]                    ram_wdata,
    input  logic [1:0]                    ram_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    import fb_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] HI_LEVEL = LW'(HI_WM);

    fifo_entry_t      fifo_din;
    fifo_entry_t      fifo_head;
    logic             push;
    logic             active;
    logic             grant_wr;
    logic             grant_vga;
    logic             grant_ai;
    logic             head_in_range;
    owner_t           owner_q;
    logic             oor_q;
    logic             miss_q;
    logic [FB_AW-1:0] addr_hold;
    logic [FB_DW-1:0] ret_data;
    logic [FB_DW-1:0] vga_q_hold;
    logic [FB_DW-1:0] ai_q_hold;

    assign push     = wr_valid && wr_ready;
    assign fifo_din = '{addr: wr_addr, data: wr_data};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (fifo_din),
        .pop     (grant_wr),
        .dout    (fifo_head),
        .level   (fifo_level),
        .ready   (wr_ready)
    );

    // Fixed-priority grant. Nothing is granted until the first clock edge
    // after reset release, which keeps every output at 0 while in reset and
    // lines the arbiter up with wr_ready rising.
    always_comb begin
        grant_wr  = 1'b0;
        grant_vga = 1'b0;
        grant_ai  = 1'b0;
        if (active) begin
            if (fifo_level >= HI_LEVEL)
                grant_wr = 1'b1;
            else if (vga_req)
                grant_vga = 1'b1;
            else if (fifo_level != '0)
                grant_wr = 1'b1;
            else if (ai_req)
                grant_ai = 1'b1;
        end
    end

    assign head_in_range = addr_in_range(fifo_head.addr, FB_WORDS);
    assign ai_gnt        = grant_ai;

    // Out-of-range writes still pop the FIFO but never assert the strobe.
    // An idle cycle parks the address on its previous value.
    always_comb begin
        ram_addr  = addr_hold;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (grant_wr) begin
            ram_addr  = fifo_head.addr;
            ram_wdata = fifo_head.data;
            ram_we    = head_in_range;
        end else if (grant_vga) begin
            ram_addr = vga_addr;
        end else if (grant_ai) begin
            ram_addr = ai_addr;
        end
    end

    // Return path: the owner tag and OOR bit travel one cycle alongside the
    // RAM read so the data can be steered and masked when it arrives.
    assign ret_data  = oor_q ? '0 : ram_q;
    assign vga_valid = (owner_q == OWN_VGA);
    assign ai_valid  = (owner_q == OWN_AI);
    assign vga_q     = vga_valid ? ret_data : vga_q_hold;
    assign ai_q      = ai_valid  ? ret_data : ai_q_hold;
    assign vga_miss  = miss_q;

    // Pipeline, hold registers and the sticky overflow flag. A new drop
    // outranks a clear arriving in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            addr_hold  <= '0;
            owner_q    <= OWN_NONE;
            oor_q      <= 1'b0;
            miss_q     <= 1'b0;
            overflow   <= 1'b0;
            vga_q_hold <= '0;
            ai_q_hold  <= '0;
        end else begin
            active    <= 1'b1;
            addr_hold <= ram_addr;
            miss_q    <= vga_req && !grant_vga;
            if (grant_vga) begin
                owner_q <= OWN_VGA;
                oor_q   <= !addr_in_range(vga_addr, FB_WORDS);
            end else if (grant_ai) begin
                owner_q <= OWN_AI;
                oor_q   <= !addr_in_range(ai_addr, FB_WORDS);
            end else begin
                owner_q <= OWN_NONE;
                oor_q   <= 1'b0;
            end
            if (wr_valid && !wr_ready)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
            if (vga_valid)
                vga_q_hold <= vga_q;
            if (ai_valid)
                ai_q_hold <= ai_q;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter.
// Two instances share the stimulus: dut uses the default watermark, dut2
// uses HI_WM = 32 so the FIFO can actually fill and refuse a write.
// A behavioural registered RAM sits behind dut; out-of-range reads return a
// nonzero pattern so masking to 0 is observable.
module tb_fb_arbiter;

    import fb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [1:0]  wr_data = '0;
    logic        vga_req = 1'b0;
    logic [14:0] vga_addr = '0;
    logic        ai_req = 1'b0;
    logic [14:0] ai_addr = '0;
    logic        clr_overflow = 1'b0;

    logic        wr_ready, vga_valid, vga_miss, ai_gnt, ai_valid, ram_we, overflow;
    logic [1:0]  vga_q, ai_q, ram_wdata;
    logic [1:0]  ram_q = '0;
    logic [14:0] ram_addr;
    logic [5:0]  fifo_level;

    logic        o2_wr_ready, o2_vga_valid, o2_vga_miss, o2_ai_gnt, o2_ai_valid, o2_ram_we, o2_overflow;
    logic [1:0]  o2_vga_q, o2_ai_q, o2_ram_wdata;
    logic [1:0]  ram_q2 = '0;
    logic [14:0] o2_ram_addr;
    logic [5:0]  o2_fifo_level;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       vv;
        logic [1:0] vq;
        logic       vm;
        logic       av;
        logic [1:0] aq;
    } ret_t;

    typedef struct {
        logic        vreq;
        logic [14:0] vaddr;
        logic        areq;
        logic [14:0] aaddr;
        logic        gnt;
        logic [14:0] raddr;
        logic        vv;
        logic [1:0]  vq;
        logic        av;
        logic [1:0]  aq;
    } vec_t;

    ret_t       sb[$];
    vec_t       vecs[10];
    logic [1:0] exp_vga_q = '0;
    logic [1:0] exp_ai_q = '0;
    logic [1:0] ram_mem [FB_WORDS];

    fb_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_q(vga_q), .vga_miss(vga_miss),
        .ai_req(ai_req), .ai_addr(ai_addr), .ai_gnt(ai_gnt), .ai_valid(ai_valid), .ai_q(ai_q),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
        .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    fb_arbiter #(.HI_WM(32)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(o2_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(o2_vga_valid), .vga_q(o2_vga_q), .vga_miss(o2_vga_miss),
        .ai_req(ai_req), .ai_addr(ai_addr), .ai_gnt(o2_ai_gnt), .ai_valid(o2_ai_valid), .ai_q(o2_ai_q),
        .ram_addr(o2_ram_addr), .ram_we(o2_ram_we), .ram_wdata(o2_ram_wdata), .ram_q(ram_q2),
        .fifo_level(o2_fifo_level), .overflow(o2_overflow), .clr_overflow(clr_overflow)
    );

    // 25 MHz clock.
    always #20 clock = ~clock;

    // Registered single-port RAM model; out-of-range reads return 2'b01 so
    // the arbiter's OOR masking is visible.
    always @(posedge clock) begin
        if (ram_we && ram_addr < 15'(FB_WORDS))
            ram_mem[ram_addr] <= ram_wdata;
        ram_q <= (ram_addr < 15'(FB_WORDS)) ? ram_mem[ram_addr] : 2'b01;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [14:0] wa, input logic [1:0] wd,
                                 input logic vr, input logic [14:0] va,
                                 input logic ar, input logic [14:0] aa, input logic clr);
        wr_valid     = wv;
        wr_addr      = wa;
        wr_data      = wd;
        vga_req      = vr;
        vga_addr     = va;
        ai_req       = ar;
        ai_addr      = aa;
        clr_overflow = clr;
        #1;
    endtask

    // Queue the expected return of the request driven this cycle; hold
    // values are tracked independently of the DUT.
    task automatic expectReturn(input logic vv, input logic [1:0] vq, input logic vm,
                                input logic av, input logic [1:0] aq);
        ret_t e;
        if (vv) exp_vga_q = vq;
        if (av) exp_ai_q = aq;
        e.vv = vv;
        e.vq = exp_vga_q;
        e.vm = vm;
        e.av = av;
        e.aq = exp_ai_q;
        sb.push_back(e);
    endtask

    task automatic tick();
        ret_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("vga_valid", 64'(vga_valid), 64'(e.vv));
            checkOutput("vga_q", 64'(vga_q), 64'(e.vq));
            checkOutput("vga_miss", 64'(vga_miss), 64'(e.vm));
            checkOutput("ai_valid", 64'(ai_valid), 64'(e.av));
            checkOutput("ai_q", 64'(ai_q), 64'(e.aq));
        end
    endtask

    task automatic resetDut();
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        sb.delete();
        exp_vga_q = '0;
        exp_ai_q  = '0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checkOutput("ready_after_reset", 64'(wr_ready), 64'd1);
    endtask

    task automatic waitDrain(input int max_cycles);
        for (int k = 0; k < max_cycles && fifo_level != 6'd0; k++)
            tick();
        checkOutput("drain_level", 64'(fifo_level), 64'd0);
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({wr_ready, vga_valid, vga_q, vga_miss, ai_gnt, ai_valid, ai_q,
                    ram_addr, ram_we, ram_wdata, fifo_level, overflow});
    endfunction

    initial begin
        for (int i = 0; i < FB_WORDS; i++)
            ram_mem[i] = 2'b00;

        // Read table: RAM holds 200+i -> i%4, 5 -> 3, 7 -> 1, 100 -> 2.
        vecs[0] = '{1'b1, 15'd200,   1'b0, 15'd0,     1'b0, 15'd200,   1'b1, 2'd0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 15'd203,   1'b0, 15'd0,     1'b0, 15'd203,   1'b1, 2'd3, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 15'd23040, 1'b0, 15'd0,     1'b0, 15'd23040, 1'b1, 2'd0, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 15'd7,     1'b0, 15'd0,     1'b0, 15'd7,     1'b1, 2'd1, 1'b0, 2'd0};
        vecs[4] = '{1'b0, 15'd0,     1'b1, 15'd100,   1'b1, 15'd100,   1'b0, 2'd0, 1'b1, 2'd2};
        vecs[5] = '{1'b1, 15'd5,     1'b1, 15'd201,   1'b0, 15'd5,     1'b1, 2'd3, 1'b0, 2'd0};
        vecs[6] = '{1'b0, 15'd0,     1'b1, 15'd201,   1'b1, 15'd201,   1'b0, 2'd0, 1'b1, 2'd1};
        vecs[7] = '{1'b0, 15'd0,     1'b0, 15'd0,     1'b0, 15'd201,   1'b0, 2'd0, 1'b0, 2'd0};
        vecs[8] = '{1'b0, 15'd0,     1'b1, 15'd23041, 1'b1, 15'd23041, 1'b0, 2'd0, 1'b1, 2'd0};
        vecs[9] = '{1'b1, 15'd5,     1'b0, 15'd0,     1'b0, 15'd5,     1'b1, 2'd3, 1'b0, 2'd0};

        // Reset state.
        #5;
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        @(posedge clock);
        #1;
        checkOutput("ready_in_reset", 64'(wr_ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checkOutput("ready_after_release", 64'(wr_ready), 64'd1);
        checkOutput("level_after_release", 64'(fifo_level), 64'd0);

        // Write then read back.
        applyStimulus(1'b1, 15'd5, 2'd3, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("empty_no_we", 64'(ram_we), 64'd0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("wr_we", 64'(ram_we), 64'd1);
        checkOutput("wr_addr", 64'(ram_addr), 64'd5);
        checkOutput("wr_wdata", 64'(ram_wdata), 64'd3);
        checkOutput("wr_level", 64'(fifo_level), 64'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b0);
        checkOutput("rd_addr", 64'(ram_addr), 64'd5);
        checkOutput("rd_we", 64'(ram_we), 64'd0);
        expectReturn(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        tick();

        // Writer waits while VGA reads every cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i == 0, 15'd7, 2'd1, 1'b1, 15'd5, 1'b0, '0, 1'b0);
            checkOutput("wait_no_we", 64'(ram_we), 64'd0);
            expectReturn(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
            tick();
        end
        checkOutput("wait_level", 64'(fifo_level), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("wait_we", 64'(ram_we), 64'd1);
        checkOutput("wait_addr", 64'(ram_addr), 64'd7);
        expectReturn(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("wait_level_done", 64'(fifo_level), 64'd0);

        // Watermark preemption.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 15'(200 + i), 2'(i % 4), 1'b1, 15'd5, 1'b0, '0, 1'b0);
            expectReturn(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
            tick();
        end
        checkOutput("wm_level", 64'(fifo_level), 64'd24);
        applyStimulus(1'b0, '0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b0);
        checkOutput("wm_we", 64'(ram_we), 64'd1);
        checkOutput("wm_addr", 64'(ram_addr), 64'd200);
        expectReturn(1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("wm_level_after", 64'(fifo_level), 64'd23);
        applyStimulus(1'b0, '0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b0);
        checkOutput("wm_vga_again", 64'(ram_addr), 64'd5);
        expectReturn(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("wm_level_hold", 64'(fifo_level), 64'd23);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        waitDrain(40);

        // Seed address 100 with shade 2 for the AI reads.
        applyStimulus(1'b1, 15'd100, 2'd2, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();

        // Table-driven read / AI / OOR vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, '0, vecs[i].vreq, vecs[i].vaddr, vecs[i].areq, vecs[i].aaddr, 1'b0);
            checkOutput($sformatf("vec%0d_gnt", i), 64'(ai_gnt), 64'(vecs[i].gnt));
            checkOutput($sformatf("vec%0d_addr", i), 64'(ram_addr), 64'(vecs[i].raddr));
            checkOutput($sformatf("vec%0d_we", i), 64'(ram_we), 64'd0);
            expectReturn(vecs[i].vv, vecs[i].vq, 1'b0, vecs[i].av, vecs[i].aq);
            tick();
        end

        // Out-of-range write is popped without a write strobe.
        applyStimulus(1'b1, 15'd23040, 2'd3, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("oor_level", 64'(fifo_level), 64'd1);
        checkOutput("oor_no_we", 64'(ram_we), 64'd0);
        tick();
        checkOutput("oor_popped", 64'(fifo_level), 64'd0);

        // Overflow on the HI_WM = 32 instance.
        resetDut();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 15'(300 + i), 2'd1, 1'b1, 15'd5, 1'b0, '0, 1'b0);
            tick();
        end
        checkOutput("ovf_full_level", 64'(o2_fifo_level), 64'd32);
        checkOutput("ovf_not_ready", 64'(o2_wr_ready), 64'd0);
        applyStimulus(1'b1, 15'd332, 2'd1, 1'b1, 15'd5, 1'b0, '0, 1'b0);
        checkOutput("ovf_pop_we", 64'(o2_ram_we), 64'd1);
        tick();
        checkOutput("ovf_set", 64'(o2_overflow), 64'd1);
        checkOutput("ovf_level", 64'(o2_fifo_level), 64'd31);
        checkOutput("ovf_dut1_clear", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b0);
            tick();
            checkOutput("ovf_sticky", 64'(o2_overflow), 64'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b1);
        tick();
        checkOutput("ovf_cleared", 64'(o2_overflow), 64'd0);
        applyStimulus(1'b1, 15'd400, 2'd2, 1'b1, 15'd5, 1'b0, '0, 1'b0);
        tick();
        checkOutput("ovf_refill_level", 64'(o2_fifo_level), 64'd32);
        checkOutput("ovf_refill_ready", 64'(o2_wr_ready), 64'd0);
        applyStimulus(1'b1, 15'd401, 2'd2, 1'b1, 15'd5, 1'b0, '0, 1'b1);
        tick();
        checkOutput("ovf_set_wins", 64'(o2_overflow), 64'd1);

        // Reset in the middle of traffic.
        resetDut();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 15'(500 + i), 2'd3, 1'b1, 15'd5, 1'b0, '0, 1'b0);
            tick();
        end
        checkOutput("mid_level", 64'(fifo_level), 64'd10);
        checkOutput("mid_inflight", 64'(vga_valid), 64'd1);
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("mid_reset_outputs", allOutputs(), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checkOutput("mid_no_valid", 64'(vga_valid), 64'd0);
        checkOutput("mid_ready", 64'(wr_ready), 64'd1);
        checkOutput("mid_level_zero", 64'(fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 160x144, 2 bpp framebuffer RAM among three requesters: the DMG capture writer, the VGA debug display reader and the AI board sampler.
- One RAM access per cycle.
- Writes are buffered in a small FIFO so the VGA scan is normally never stalled.
- Sits between the capture logic, the VGA module, the AI logic and the framebuffer RAM in FPGAtetrisAI, in the 25 MHz VGA clock domain.

Parameters:
- FB_WORDS, 23040, number of valid framebuffer words (160*144); any address at or above this is out of range (OOR).
- FIFO_DEPTH, 32, write FIFO entries; power of two.
- HI_WM, 24, FIFO level at which the writer preempts VGA; range 1..FIFO_DEPTH.

Ports:
- clock  in  1  VGA_clk, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  capture writer offers a pixel.
- wr_ready  out  1  FIFO can accept; registered, equals level < FIFO_DEPTH.
- wr_addr  in  15  pixel address.
- wr_data  in  2  pixel shade.
- vga_req  in  1  VGA read request for this cycle; no hold required.
- vga_addr  in  15  VGA read address.
- vga_valid  out  1  vga_q is valid (read data for the request one cycle earlier).
- vga_q  out  2  VGA read data.
- vga_miss  out  1  pulse one cycle after a VGA request lost arbitration.
- ai_req  in  1  AI read request; held with ai_addr stable until ai_gnt.
- ai_addr  in  15  AI read address.
- ai_gnt  out  1  combinational; high in the cycle the AI access is issued.
- ai_valid  out  1  ai_q is valid; one cycle after ai_gnt.
- ai_q  out  2  AI read data.
- ram_addr  out  15  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  2  RAM write data.
- ram_q  in  2  RAM read data; registered RAM, one-cycle latency.
- fifo_level  out  6  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a write was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, while reset_n is low):
  - FIFO is emptied.
  - All outputs are 0, including wr_ready.
  - wr_ready rises on the first clock edge after reset_n is released.
  - A reset asserted mid-operation discards all FIFO contents and any in-flight read; no valid strobe is produced for reads issued before the reset.
- FIFO:
  - Push when wr_valid && wr_ready; stores {addr, data}.
  - A push and a pop in the same cycle leave the level unchanged.
  - wr_valid while wr_ready is low drops the pixel and sets overflow.
  - If overflow is set and cleared in the same cycle, set wins.
- Arbitration: evaluated combinationally each cycle; exactly one grant or none.
  1. FIFO level >= HI_WM: writer (pops one entry).
  2. Otherwise vga_req: VGA.
  3. Otherwise FIFO non-empty: writer.
  4. Otherwise ai_req: AI (ai_gnt high).
  5. Otherwise idle: ram_we = 0, ram_addr holds its previous value.
- Writer grant:
  - ram_addr/ram_wdata come from the FIFO head.
  - ram_we = 1 only if the address is in range; OOR writes are popped and discarded.
- Read grants:
  - ram_addr = requester's address, ram_we = 0.
  - An owner tag {NONE, VGA, AI} plus an OOR bit are registered for the return cycle.
- Return cycle:
  - Owner VGA: vga_valid = 1, vga_q = ram_q, or 0 if OOR.
  - Owner AI: likewise on ai_valid/ai_q.
  - Valid strobes are single-cycle.
  - vga_q and ai_q hold their last value when their valid is low.
- vga_miss: vga_req high but not granted -> vga_miss = 1 and vga_valid = 0 in the next cycle. The VGA module repeats its previous pixel.
- AI can starve indefinitely; this is by design.

Decomposition:
- Package fb_pkg:
  - FB_AW = 15, FB_DW = 2, FB_WORDS default.
  - Owner enum OWN_NONE / OWN_VGA / OWN_AI.
  - FIFO entry struct {addr, data}.
- Sub-module fb_wr_fifo: synchronous FIFO with registered ready, level output and push/pop. The arbitration, owner pipeline and overflow logic stay in fb_arbiter.

Test Plan:
- Write, then read: push addr 5, data 3 with VGA idle. Next cycle ram_we = 1, ram_addr = 5. Then vga_req addr 5 -> vga_valid = 1 and vga_q = 3 one cycle later.
- Writer waits for VGA: vga_req held high for 10 cycles, push 1 pixel. No ram_we during those cycles, fifo_level = 1. The write issues in the first cycle after vga_req drops.
- Watermark preemption: vga_req held high, push 24 pixels back-to-back. At level 24 the writer takes a cycle, vga_miss pulses one cycle later with vga_valid = 0, and the level returns to 23.
- Overflow: HI_WM = 32, vga_req held high, push 33 pixels. The 33rd is refused, overflow = 1 and stays 1 until clr_overflow. clr_overflow together with a new drop -> overflow stays 1.
- AI grant: FIFO empty, vga_req = 0, ai_req addr 100 (RAM holds 2). ai_gnt is high the same cycle; next cycle ai_valid = 1, ai_q = 2. With vga_req = 1 in that cycle, ai_gnt = 0.
- OOR and reset:
  - Push addr 23040 -> popped, no ram_we.
  - VGA read of 23040 -> vga_valid = 1, vga_q = 0.
  - Pull reset_n low at fifo_level 10 -> level 0 and all outputs 0 immediately.
